// File: rtl/alu_fn_sequencer_if.sv
// Handshake and datapath bundle between the instruction source, the ALU and the sequencer.
// Carries the flags vector only when ALU_FLAGS_EN is defined.
interface alu_fn_sequencer_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic [2:0] f_code;
  logic       f_drive;
  logic       reg_load_a;
  logic       reg_load_d;
  logic [7:0] reg_wdata;
  logic       done;
  logic       illegal;
`ifdef ALU_FLAGS_EN
  logic [2:0] flags;
`endif

  modport master (
    output instr_valid, instr, alu_result, alu_carry,
    input  instr_ready, f_code, f_drive, reg_load_a, reg_load_d,
           reg_wdata, done, illegal
`ifdef ALU_FLAGS_EN
    , flags
`endif
  );

  modport slave (
    input  instr_valid, instr, alu_result, alu_carry,
    output instr_ready, f_code, f_drive, reg_load_a, reg_load_d,
           reg_wdata, done, illegal
`ifdef ALU_FLAGS_EN
    , flags
`endif
  );
endinterface

// File: rtl/alu_fn_sequencer.sv
// Drives the 3-bit ALU function code for a relay settle time, then samples the result and loads A or D.
// Optional status flags {sign, carry, zero} are built when ALU_FLAGS_EN is defined.
//
// state  | meaning
// IDLE   | ready for an instruction byte, function lines released
// SETTLE | function lines energised, settle counter running down
// WRITE  | result registered, load strobe and done pulse
// ERR    | non-ALU byte accepted, illegal pulse
module alu_fn_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_fn_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WRITE  = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] FN_ADD   = 3'b000;
  localparam logic [2:0] FN_INC   = 3'b001;
  localparam logic [2:0] FN_NULL  = 3'b111;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] fff_q, fff_d;
  logic       dst_q, dst_d;
  logic [7:0] wdata_q, wdata_d;

  logic       ready;
  logic       drive;
  logic [2:0] fcode;
  logic       load_a;
  logic       load_d;
  logic       done_p;
  logic       illegal_p;

`ifdef ALU_FLAGS_EN
  logic       carry_q, carry_d;
  logic [2:0] flags_q, flags_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fff_q   <= '0;
      dst_q   <= 1'b0;
      wdata_q <= '0;
`ifdef ALU_FLAGS_EN
      carry_q <= 1'b0;
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fff_q   <= fff_d;
      dst_q   <= dst_d;
      wdata_q <= wdata_d;
`ifdef ALU_FLAGS_EN
      carry_q <= carry_d;
      flags_q <= flags_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fff_d     = fff_q;
    dst_d     = dst_q;
    wdata_d   = wdata_q;
    ready     = 1'b0;
    drive     = 1'b0;
    fcode     = '0;
    load_a    = 1'b0;
    load_d    = 1'b0;
    done_p    = 1'b0;
    illegal_p = 1'b0;
`ifdef ALU_FLAGS_EN
    carry_d   = carry_q;
    flags_d   = flags_q;
`endif

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) begin
          if (bus.instr[7:4] == 4'b1000) begin
            state_d = S_SETTLE;
            cnt_d   = CNT_INIT;
            fff_d   = bus.instr[2:0];
            dst_d   = bus.instr[3];
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_SETTLE: begin
        drive = 1'b1;
        fcode = fff_q;
        if (cnt_q == '0) begin
          wdata_d = bus.alu_result;
`ifdef ALU_FLAGS_EN
          carry_d = bus.alu_carry;
`endif
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_WRITE: begin
        drive  = 1'b1;
        fcode  = fff_q;
        done_p = 1'b1;
        if (fff_q != FN_NULL) begin
          load_a = ~dst_q;
          load_d = dst_q;
`ifdef ALU_FLAGS_EN
          // Only ADD and INC produce a meaningful carry out of the relay adder.
          flags_d = {wdata_q[7],
                     ((fff_q == FN_ADD) || (fff_q == FN_INC)) ? carry_q : 1'b0,
                     (wdata_q == 8'd0)};
`endif
        end
        state_d = S_IDLE;
      end

      S_ERR: begin
        illegal_p = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.instr_ready = ready;
  assign bus.f_drive     = drive;
  assign bus.f_code      = fcode;
  assign bus.reg_load_a  = load_a;
  assign bus.reg_load_d  = load_d;
  assign bus.done        = done_p;
  assign bus.illegal     = illegal_p;
  assign bus.reg_wdata   = wdata_q;
`ifdef ALU_FLAGS_EN
  assign bus.flags       = flags_q;
`endif

endmodule

// File: tb/tb_alu_fn_sequencer.sv
// Self-checking bench for alu_fn_sequencer: table vectors, back-to-back and reset corner cases,
// then random instructions checked against a transaction-level timing model.
module tb_alu_fn_sequencer;
  localparam int S = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [7:0] m_wdata;
`ifdef ALU_FLAGS_EN
  logic [2:0] m_flags;
`endif

  alu_fn_sequencer_if bus ();

  alu_fn_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ins;
    logic [7:0] res;
    logic       car;
    logic       la;
    logic       ld;
    logic       dn;
    logic       ill;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge of the cycle where instr_ready is back.
  task automatic do_op(input logic [7:0] ins, input logic [7:0] res, input logic car,
                       input logic e_la, input logic e_ld, input logic e_dn, input logic e_ill,
                       input logic keep_valid, input logic [7:0] next_ins);
    logic       is_alu;
    logic [2:0] fff;
    int k, ready_k, drive_n, fbad, done_n, done_k, ill_n, ill_k, stray;
    logic la, ld;
    logic [7:0] wd;
    bit got;
    is_alu = (ins[7:4] == 4'b1000);
    fff    = ins[2:0];
    k = 0; ready_k = 0; drive_n = 0; fbad = 0; done_n = 0; done_k = 0;
    ill_n = 0; ill_k = 0; stray = 0; la = 1'b0; ld = 1'b0; wd = 8'h00; got = 0;

    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.alu_result  = res;
    bus.alu_carry   = car;
    chk("ready_before_accept", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (keep_valid) bus.instr = next_ins;
    else begin
      bus.instr_valid = 1'b0;
      bus.instr       = 8'h00;
    end

    while (k < 300 && !got) begin
      @(negedge clk);
      k++;
      if (bus.f_drive) begin
        drive_n++;
        if (bus.f_code !== fff) fbad++;
      end else if (bus.f_code !== 3'b000) fbad++;
      if (bus.done) begin
        done_n++;
        done_k = k;
        la = bus.reg_load_a;
        ld = bus.reg_load_d;
        wd = bus.reg_wdata;
      end else if (bus.reg_load_a || bus.reg_load_d) stray++;
      if (bus.illegal) begin
        ill_n++;
        ill_k = k;
      end
      if (bus.instr_ready) begin
        got = 1;
        ready_k = k;
      end
    end

    if (is_alu) m_wdata = res;
`ifdef ALU_FLAGS_EN
    if (is_alu && fff != 3'b111)
      m_flags = {res[7], (fff == 3'b000 || fff == 3'b001) ? car : 1'b0, (res == 8'h00)};
`endif

    chk("ready_cycle",    ready_k, is_alu ? S + 2 : 2);
    chk("drive_cycles",   drive_n, is_alu ? S + 1 : 0);
    chk("f_code_bad",     fbad, 0);
    chk("done_count",     done_n, {31'd0, e_dn});
    chk("done_cycle",     done_k, e_dn ? S + 1 : 0);
    chk("load_a",         {31'd0, la}, {31'd0, e_la});
    chk("load_d",         {31'd0, ld}, {31'd0, e_ld});
    chk("stray_strobe",   stray, 0);
    chk("illegal_count",  ill_n, {31'd0, e_ill});
    chk("illegal_cycle",  ill_k, e_ill ? 1 : 0);
    if (e_dn) chk("wdata_at_done", {24'd0, wd}, {24'd0, res});
    chk("wdata_after",    {24'd0, bus.reg_wdata}, {24'd0, m_wdata});
`ifdef ALU_FLAGS_EN
    chk("flags_after",    {29'd0, bus.flags}, {29'd0, m_flags});
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},   {31'd0, bus.instr_ready}, 32'd1);
    chk({tag, "_drive"},   {31'd0, bus.f_drive}, 32'd0);
    chk({tag, "_fcode"},   {29'd0, bus.f_code}, 32'd0);
    chk({tag, "_loads"},   {30'd0, bus.reg_load_a, bus.reg_load_d}, 32'd0);
    chk({tag, "_done"},    {30'd0, bus.done, bus.illegal}, 32'd0);
    chk({tag, "_wdata"},   {24'd0, bus.reg_wdata}, 32'd0);
`ifdef ALU_FLAGS_EN
    chk({tag, "_flags"},   {29'd0, bus.flags}, 32'd0);
`endif
  endtask

  vec_t vecs[8];

  initial begin
    logic [7:0] r_ins, r_res;
    logic       r_car, r_alu, r_null;
    int         bad;
    n_tests = 0;
    n_fail  = 0;
    m_wdata = 8'h00;
`ifdef ALU_FLAGS_EN
    m_flags = 3'b000;
`endif
    vecs[0] = '{8'h80, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h8F, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h40, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h89, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h86, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h87, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h8C, 8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    bus.alu_result  = 8'h00;
    bus.alu_carry   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].ins, vecs[i].res, vecs[i].car,
            vecs[i].la, vecs[i].ld, vecs[i].dn, vecs[i].ill, 1'b0, 8'h00);

    // Back-to-back with instr_valid held high; second byte swapped in after the first accept.
    do_op(8'h82, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h8D);
    do_op(8'h8D, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Reset during the second SETTLE cycle aborts the instruction.
    bus.instr_valid = 1'b1;
    bus.instr       = 8'h80;
    bus.alu_result  = 8'h77;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    m_wdata = 8'h00;
`ifdef ALU_FLAGS_EN
    m_flags = 3'b000;
`endif
    bad = 0;
    for (int c = 0; c < S + 3; c++) begin
      @(negedge clk);
      if (bus.done || bus.reg_load_a || bus.reg_load_d || bus.f_drive || !bus.instr_ready) bad++;
    end
    chk("abort_no_activity", bad, 0);

    for (int i = 0; i < 24; i++) begin
      r_ins = ($urandom_range(0, 2) != 0) ? {4'b1000, 4'($urandom_range(0, 15))}
                                          : 8'($urandom_range(0, 255));
      r_res  = 8'($urandom_range(0, 255));
      r_car  = 1'($urandom_range(0, 1));
      r_alu  = (r_ins >= 8'h80 && r_ins <= 8'h8F);
      r_null = (r_ins % 8 == 7);
      do_op(r_ins, r_res, r_car,
            r_alu && !r_null && (r_ins < 8'h88),
            r_alu && !r_null && (r_ins >= 8'h88),
            r_alu, !r_alu, 1'b0, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
